id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/cpu_pkg.sv | 44 ++++
 rtl/hazard_detect.sv | 18 +
 rtl/id_ex_stage.sv | 104 ++++++++++
 tb/tb_id_ex_stage.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: the decoded control bundle, the bubble constant,
// opcode values and ALU operation encodings.
package cpu_pkg;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       branch;
    logic       mem_read;
    logic       mem_2_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic       jump;
  } ctrl_t;

  localparam int unsigned CtrlWidth = 10;

  // Bit positions of each ctrl_t field within the packed vector.
  localparam int unsigned CTRL_ALU_OP_HI = 9;
  localparam int unsigned CTRL_ALU_OP_LO = 8;
  localparam int unsigned CTRL_REG_DST   = 7;
  localparam int unsigned CTRL_BRANCH    = 6;
  localparam int unsigned CTRL_MEM_READ  = 5;
  localparam int unsigned CTRL_MEM_2_REG = 4;
  localparam int unsigned CTRL_MEM_WRITE = 3;
  localparam int unsigned CTRL_ALU_SRC   = 2;
  localparam int unsigned CTRL_REG_WRITE = 1;
  localparam int unsigned CTRL_JUMP      = 0;

  localparam ctrl_t CTRL_BUBBLE = '0;

  localparam logic [5:0] ALU_R = 6'h00;
  localparam logic [5:0] ADDI  = 6'h08;
  localparam logic [5:0] BEQ   = 6'h04;
  localparam logic [5:0] J     = 6'h02;
  localparam logic [5:0] LW    = 6'h23;
  localparam logic [5:0] SW    = 6'h2B;

  localparam logic [1:0] ALU_OP_ADD    = 2'd0;
  localparam logic [1:0] ALU_OP_SUB    = 2'd1;
  localparam logic [1:0] ALU_OP_R_TYPE = 2'd2;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection (purely combinational).
// Ports:
//   mem_read_ex - EX-stage instruction is a load
//   rt_ex       - destination register of the EX-stage load
//   rs_id/rt_id - source register fields of the ID-stage instruction
//   hazard      - ID instruction reads a register the EX load has yet to produce
module hazard_detect (
  input  logic       mem_read_ex,
  input  logic [4:0] rt_ex,
  input  logic [4:0] rs_id,
  input  logic [4:0] rt_id,
  output logic       hazard
);

  // rt is compared for every opcode; a spurious stall on I-type is harmless.
  assign hazard = mem_read_ex && (rt_ex != 5'd0) && ((rt_ex == rs_id) || (rt_ex == rt_id));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall generation.
// Ports:
//   clk, arst_n        - clock, asynchronous active-low reset
//   enable             - pipeline advance; 0 freezes all state
//   flush              - squash: the EX stage receives a bubble
//   ctrl_id, instr_id  - decoded control bundle and raw instruction from ID
//   pc_id, rdata1_id, rdata2_id, imm_id - ID-stage data
//   ctrl_ex ... funct_ex - registered EX-stage copies
//   stall_id           - combinational stall request for PC and IF/ID
//   stall_cnt          - saturating count of inserted load-use bubbles
module id_ex_stage
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        arst_n,
  input  logic        enable,
  input  logic        flush,
  input  logic [9:0]  ctrl_id,
  input  logic [31:0] instr_id,
  input  logic [31:0] pc_id,
  input  logic [31:0] rdata1_id,
  input  logic [31:0] rdata2_id,
  input  logic [31:0] imm_id,
  output logic [9:0]  ctrl_ex,
  output logic [31:0] pc_ex,
  output logic [31:0] rdata1_ex,
  output logic [31:0] rdata2_ex,
  output logic [31:0] imm_ex,
  output logic [4:0]  rs_ex,
  output logic [4:0]  rt_ex,
  output logic [4:0]  rd_ex,
  output logic [5:0]  funct_ex,
  output logic        stall_id,
  output logic [15:0] stall_cnt
);

  ctrl_t       ctrl_q, ctrl_d;
  logic [31:0] pc_q, rdata1_q, rdata2_q, imm_q;
  logic [4:0]  rs_q, rt_q, rd_q;
  logic [5:0]  funct_q;
  logic [15:0] cnt_q, cnt_d;
  logic        hazard;

  hazard_detect u_hazard_detect (
    .mem_read_ex (ctrl_q.mem_read),
    .rt_ex       (rt_q),
    .rs_id       (instr_id[25:21]),
    .rt_id       (instr_id[20:16]),
    .hazard      (hazard)
  );

  // A flush already squashes the consumer, so no stall is needed or counted.
  assign stall_id = hazard && enable && !flush;

  always_comb begin
    ctrl_d = ctrl_t'(ctrl_id);
    if (flush || hazard) begin
      ctrl_d = CTRL_BUBBLE;
    end
    cnt_d = cnt_q;
    if (stall_id && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ctrl_q   <= CTRL_BUBBLE;
      pc_q     <= '0;
      rdata1_q <= '0;
      rdata2_q <= '0;
      imm_q    <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      rd_q     <= '0;
      funct_q  <= '0;
      cnt_q    <= '0;
    end else if (enable) begin
      ctrl_q   <= ctrl_d;
      // Data always loads; under a bubble its contents are ignored downstream.
      pc_q     <= pc_id;
      rdata1_q <= rdata1_id;
      rdata2_q <= rdata2_id;
      imm_q    <= imm_id;
      rs_q     <= instr_id[25:21];
      rt_q     <= instr_id[20:16];
      rd_q     <= instr_id[15:11];
      funct_q  <= instr_id[5:0];
      cnt_q    <= cnt_d;
    end
  end

  assign ctrl_ex   = ctrl_q;
  assign pc_ex     = pc_q;
  assign rdata1_ex = rdata1_q;
  assign rdata2_ex = rdata2_q;
  assign imm_ex    = imm_q;
  assign rs_ex     = rs_q;
  assign rt_ex     = rt_q;
  assign rd_ex     = rd_q;
  assign funct_ex  = funct_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: the driver pushes the expected response of
// each cycle, the monitor pops it, checks stall_id before the edge and the
// registered outputs just after it.
module tb_id_ex_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        enable, flush;
  logic [9:0]  ctrl_id;
  logic [31:0] instr_id, pc_id, rdata1_id, rdata2_id, imm_id;
  logic [9:0]  ctrl_ex;
  logic [31:0] pc_ex, rdata1_ex, rdata2_ex, imm_ex;
  logic [4:0]  rs_ex, rt_ex, rd_ex;
  logic [5:0]  funct_ex;
  logic        stall_id;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .enable    (enable),
    .flush     (flush),
    .ctrl_id   (ctrl_id),
    .instr_id  (instr_id),
    .pc_id     (pc_id),
    .rdata1_id (rdata1_id),
    .rdata2_id (rdata2_id),
    .imm_id    (imm_id),
    .ctrl_ex   (ctrl_ex),
    .pc_ex     (pc_ex),
    .rdata1_ex (rdata1_ex),
    .rdata2_ex (rdata2_ex),
    .imm_ex    (imm_ex),
    .rs_ex     (rs_ex),
    .rt_ex     (rt_ex),
    .rd_ex     (rd_ex),
    .funct_ex  (funct_ex),
    .stall_id  (stall_id),
    .stall_cnt (stall_cnt)
  );

  localparam logic [9:0] C_ADDI = 10'h006;
  localparam logic [9:0] C_LW   = 10'h036;
  localparam logic [9:0] C_R    = 10'h282;

  typedef struct {
    logic        stall;
    logic [9:0]  ctrl;
    logic [31:0] pc, r1, r2, imm;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  funct;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Values last loaded into the data registers (they load whenever enabled).
  logic [31:0] m_pc = '0, m_r1 = '0, m_r2 = '0, m_imm = '0, m_instr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [4:0] rd,
                                     input logic [5:0] fn);
    return {op, rs, rt, rd, 5'd0, fn};
  endfunction

  task automatic step(input logic en, input logic fl, input logic [9:0] c,
                      input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] imm,
                      input logic exp_stall, input logic [9:0] exp_ctrl,
                      input logic [15:0] exp_cnt);
    exp_t e;
    @(negedge clk);
    enable = en; flush = fl; ctrl_id = c; instr_id = ins;
    pc_id = pc; rdata1_id = pc + 32'h100; rdata2_id = pc + 32'h200; imm_id = imm;
    if (en) begin
      m_pc = pc; m_r1 = pc + 32'h100; m_r2 = pc + 32'h200; m_imm = imm; m_instr = ins;
    end
    e.stall = exp_stall; e.ctrl = exp_ctrl; e.cnt = exp_cnt;
    e.pc = m_pc; e.r1 = m_r1; e.r2 = m_r2; e.imm = m_imm;
    e.rs = m_instr[25:21]; e.rt = m_instr[20:16]; e.rd = m_instr[15:11]; e.funct = m_instr[5:0];
    exp_q.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctrl"}, {22'd0, ctrl_ex}, 32'd0);
    chk({tag, "_pc"}, pc_ex, 32'd0);
    chk({tag, "_r1"}, rdata1_ex, 32'd0);
    chk({tag, "_r2"}, rdata2_ex, 32'd0);
    chk({tag, "_imm"}, imm_ex, 32'd0);
    chk({tag, "_regs"}, {17'd0, rs_ex, rt_ex, rd_ex}, 32'd0);
    chk({tag, "_funct"}, {26'd0, funct_ex}, 32'd0);
    chk({tag, "_cnt"}, {16'd0, stall_cnt}, 32'd0);
    chk({tag, "_stall"}, {31'd0, stall_id}, 32'd0);
  endtask

  // Monitor: stall_id is sampled mid-low-phase, registers just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("stall_id", {31'd0, stall_id}, {31'd0, e.stall});
        @(posedge clk);
        #1;
        chk("ctrl_ex", {22'd0, ctrl_ex}, {22'd0, e.ctrl});
        chk("pc_ex", pc_ex, e.pc);
        chk("rdata1_ex", rdata1_ex, e.r1);
        chk("rdata2_ex", rdata2_ex, e.r2);
        chk("imm_ex", imm_ex, e.imm);
        chk("rs_ex", {27'd0, rs_ex}, {27'd0, e.rs});
        chk("rt_ex", {27'd0, rt_ex}, {27'd0, e.rt});
        chk("rd_ex", {27'd0, rd_ex}, {27'd0, e.rd});
        chk("funct_ex", {26'd0, funct_ex}, {26'd0, e.funct});
        chk("stall_cnt", {16'd0, stall_cnt}, {16'd0, e.cnt});
      end
    end
  end

  task automatic drain();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [31:0] i_addi, i_lw8, i_lw0, i_r8, i_r0, i_r18;
    i_addi = mk(ADDI, 5'd1, 5'd2, 5'd0, 6'd5);
    i_lw8  = mk(LW, 5'd3, 5'd8, 5'd0, 6'd4);
    i_lw0  = mk(LW, 5'd0, 5'd0, 5'd0, 6'd0);
    i_r8   = mk(ALU_R, 5'd8, 5'd9, 5'd10, 6'h20);
    i_r0   = mk(ALU_R, 5'd0, 5'd0, 5'd11, 6'h22);
    i_r18  = mk(ALU_R, 5'd1, 5'd8, 5'd12, 6'h24);

    arst_n = 1'b0; enable = 1'b0; flush = 1'b0; ctrl_id = '0; instr_id = '0;
    pc_id = '0; rdata1_id = '0; rdata2_id = '0; imm_id = '0;
    #17;
    check_zero("rst_init");
    arst_n = 1'b1;

    step(1'b1, 1'b0, C_ADDI, i_addi, 32'h4, 32'd5, 1'b0, C_ADDI, 16'd0);
    drain();
    // Reset asserted mid-cycle must clear outputs without a clock edge.
    #2 arst_n = 1'b0;
    #1 check_zero("rst_async");
    m_pc = '0; m_r1 = '0; m_r2 = '0; m_imm = '0; m_instr = '0;
    #2 arst_n = 1'b1;

    step(1'b1, 1'b0, C_ADDI, i_addi, 32'h4, 32'd5, 1'b0, C_ADDI, 16'd0);
    // Load-use on rs.
    step(1'b1, 1'b0, C_LW, i_lw8, 32'h8, 32'd4, 1'b0, C_LW, 16'd0);
    step(1'b1, 1'b0, C_R, i_r8, 32'hC, 32'd0, 1'b1, 10'h000, 16'd1);
    step(1'b1, 1'b0, C_R, i_r8, 32'hC, 32'd0, 1'b0, C_R, 16'd1);
    // Register 0 never stalls.
    step(1'b1, 1'b0, C_LW, i_lw0, 32'h10, 32'd0, 1'b0, C_LW, 16'd1);
    step(1'b1, 1'b0, C_R, i_r0, 32'h14, 32'd0, 1'b0, C_R, 16'd1);
    // Flush beats hazard (dependence on rt).
    step(1'b1, 1'b0, C_LW, i_lw8, 32'h18, 32'd4, 1'b0, C_LW, 16'd1);
    step(1'b1, 1'b1, C_R, i_r18, 32'h1C, 32'd0, 1'b0, 10'h000, 16'd1);
    step(1'b1, 1'b0, C_R, i_r18, 32'h20, 32'd0, 1'b0, C_R, 16'd1);
    // Freeze with a hazard pattern present and changing inputs.
    step(1'b1, 1'b0, C_LW, i_lw8, 32'h24, 32'd4, 1'b0, C_LW, 16'd1);
    step(1'b0, 1'b0, C_R, i_r8, 32'h28, 32'd7, 1'b0, C_LW, 16'd1);
    step(1'b0, 1'b0, C_ADDI, i_r18, 32'h2C, 32'd8, 1'b0, C_LW, 16'd1);
    step(1'b0, 1'b1, C_R, i_addi, 32'h30, 32'd9, 1'b0, C_LW, 16'd1);
    step(1'b1, 1'b0, C_R, i_r8, 32'h34, 32'd0, 1'b1, 10'h000, 16'd2);
    step(1'b1, 1'b0, C_R, i_r8, 32'h34, 32'd0, 1'b0, C_R, 16'd2);
    // Reset in the middle of a pending stall.
    step(1'b1, 1'b0, C_LW, i_lw8, 32'h38, 32'd4, 1'b0, C_LW, 16'd2);
    drain();
    @(negedge clk);
    instr_id = i_r8; ctrl_id = C_R; enable = 1'b1; flush = 1'b0;
    #1 chk("pre_rst_stall", {31'd0, stall_id}, 32'd1);
    arst_n = 1'b0;
    #1 check_zero("rst_stall");
    m_pc = '0; m_r1 = '0; m_r2 = '0; m_imm = '0; m_instr = '0;
    #1 arst_n = 1'b1;
    step(1'b1, 1'b0, C_R, i_r8, 32'h3C, 32'd0, 1'b0, C_R, 16'd0);
    drain();

    // Saturation: hold the hazard high for more cycles than the counter range.
    @(negedge clk);
    enable = 1'b1; flush = 1'b0; ctrl_id = C_R; instr_id = i_r8;
    force dut.hazard = 1'b1;
    repeat (65537) @(posedge clk);
    #1 chk("sat_cnt", {16'd0, stall_cnt}, 32'h0000FFFF);
    repeat (4) @(posedge clk);
    #1 chk("sat_hold", {16'd0, stall_cnt}, 32'h0000FFFF);
    chk("sat_stall", {31'd0, stall_id}, 32'd1);
    release dut.hazard;

    drain();
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
